// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_ctrl
// Description : Periodic multi-channel ADC scan sequencer with per-channel
//               mux settling, conversion averaging and conversion timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl #(
    parameter int SETTLE   = 16,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  ch_mask,
    input  logic [15:0] period,
    input  logic        err_clr,
    output logic        conv_req,
    input  logic        conv_done,
    input  logic [11:0] conv_data,
    output logic [1:0]  mux_sel,
    output logic        result_valid,
    output logic [1:0]  result_ch,
    output logic [11:0] result_data,
    output logic        scan_done,
    output logic        busy,
    output logic [3:0]  err_flags
);

    localparam int c_ACC_W  = 12 + AVG_LOG2;
    localparam int c_SCNT_W = AVG_LOG2 + 1;

    localparam logic [c_SCNT_W-1:0] c_SCNT_ONE   = c_SCNT_W'(1);
    localparam logic [c_SCNT_W-1:0] c_NSAMP      = c_SCNT_W'(1 << AVG_LOG2);
    localparam logic [7:0]          c_SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [15:0]         c_TMO_LAST    = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_PERIOD = 3'd1,
        S_SETTLE      = 3'd2,
        S_REQ         = 3'd3,
        S_WAIT_DONE   = 3'd4,
        S_NEXT        = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [3:0]            r_mask;
    logic [1:0]            r_ch;
    logic [7:0]            r_settle_cnt;
    logic [15:0]           r_tmo_cnt;
    logic [15:0]           r_per_cnt;
    logic [c_ACC_W-1:0]    r_acc;
    logic [c_SCNT_W-1:0]   r_scnt;

    logic                  r_conv_req;
    logic                  r_busy;
    logic                  r_result_valid;
    logic                  r_scan_done;
    logic [1:0]            r_result_ch;
    logic [11:0]           r_result_data;
    logic [3:0]            r_err;

    logic [3:0]            w_higher;
    logic                  w_period_hit;
    logic [c_ACC_W-1:0]    w_sum;
    logic [c_SCNT_W-1:0]   w_scnt_inc;
    logic                  w_start_scan;
    logic                  w_next_ch;
    logic                  w_result;
    logic                  w_scan_end;
    logic                  w_timeout;
    logic                  w_sample;
    logic                  w_clear_acc;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [3:0] f_above(input logic [1:0] ch);
        case (ch)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1100;
            2'd2:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    assign w_higher     = r_mask & f_above(r_ch);
    // Also true when the scan overran the period, so the next scan starts at once.
    assign w_period_hit = ({1'b0, r_per_cnt} + 17'd1) >= {1'b0, period};
    assign w_sum        = r_acc + c_ACC_W'(conv_data);
    assign w_scnt_inc   = r_scnt + c_SCNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start_scan = 1'b0;
        w_next_ch    = 1'b0;
        w_result     = 1'b0;
        w_scan_end   = 1'b0;
        w_timeout    = 1'b0;
        w_sample     = 1'b0;
        w_clear_acc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && (ch_mask != 4'd0)) begin
                    w_next_state = S_SETTLE;
                    w_start_scan = 1'b1;
                end
            end
            S_WAIT_PERIOD: begin
                if (!enable) begin
                    w_next_state = S_IDLE;
                end else if (w_period_hit) begin
                    if (ch_mask == 4'd0) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_SETTLE;
                        w_start_scan = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (!enable) begin
                    w_next_state = S_IDLE;
                    w_clear_acc  = 1'b1;
                end else if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (conv_done) begin
                    w_sample = 1'b1;
                    if (!enable) begin
                        w_next_state = S_IDLE;
                        w_clear_acc  = 1'b1;
                    end else if (w_scnt_inc == c_NSAMP) begin
                        w_next_state = S_NEXT;
                        w_result     = 1'b1;
                        w_scan_end   = (w_higher == 4'd0);
                        w_clear_acc  = 1'b1;
                    end else begin
                        w_next_state = S_REQ;
                    end
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_clear_acc = 1'b1;
                    if (!enable) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_NEXT;
                        w_scan_end   = (w_higher == 4'd0);
                    end
                end
            end
            S_NEXT: begin
                if (!enable) begin
                    w_next_state = S_IDLE;
                end else if (w_higher != 4'd0) begin
                    w_next_state = S_SETTLE;
                    w_next_ch    = 1'b1;
                end else if (w_period_hit) begin
                    if (ch_mask == 4'd0) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_SETTLE;
                        w_start_scan = 1'b1;
                    end
                end else begin
                    w_next_state = S_WAIT_PERIOD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask         <= 4'd0;
            r_ch           <= 2'd0;
            r_settle_cnt   <= 8'd0;
            r_tmo_cnt      <= 16'd0;
            r_per_cnt      <= 16'd0;
            r_acc          <= '0;
            r_scnt         <= '0;
            r_conv_req     <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_scan_done    <= 1'b0;
            r_result_ch    <= 2'd0;
            r_result_data  <= 12'd0;
            r_err          <= 4'd0;
        end else begin
            if (w_start_scan) begin
                r_mask <= ch_mask;
                r_ch   <= f_lowest(ch_mask);
            end else if (w_next_ch) begin
                r_ch   <= f_lowest(w_higher);
            end

            r_settle_cnt <= (r_state == S_SETTLE)    ? r_settle_cnt + 8'd1 : 8'd0;
            r_tmo_cnt    <= (r_state == S_WAIT_DONE) ? r_tmo_cnt + 16'd1   : 16'd0;

            if (w_start_scan) begin
                r_per_cnt <= 16'd0;
            end else if (r_per_cnt != 16'hFFFF) begin
                r_per_cnt <= r_per_cnt + 16'd1;
            end

            if (w_start_scan || w_clear_acc) begin
                r_acc  <= '0;
                r_scnt <= '0;
            end else if (w_sample) begin
                r_acc  <= w_sum;
                r_scnt <= w_scnt_inc;
            end

            // Status outputs are loaded from the next state so they line up with it.
            r_conv_req     <= (w_next_state == S_REQ);
            r_busy         <= (w_next_state == S_SETTLE) || (w_next_state == S_REQ) ||
                              (w_next_state == S_WAIT_DONE) || (w_next_state == S_NEXT);
            r_result_valid <= w_result;
            r_scan_done    <= w_scan_end;

            if (w_result) begin
                r_result_ch   <= r_ch;
                r_result_data <= w_sum[c_ACC_W-1:AVG_LOG2];
            end

            r_err <= (err_clr ? 4'd0 : r_err) | (w_timeout ? (4'b0001 << r_ch) : 4'd0);
        end
    end

    assign conv_req     = r_conv_req;
    assign mux_sel      = r_ch;
    assign result_valid = r_result_valid;
    assign result_ch    = r_result_ch;
    assign result_data  = r_result_data;
    assign scan_done    = r_scan_done;
    assign busy         = r_busy;
    assign err_flags    = r_err;

endmodule
`default_nettype wire

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 16, mux settling cycles before the first conversion of each channel (1..255).
REQ-002 Parameter AVG_LOG2, default 2, log2 of conversions averaged per channel (0..4).
REQ-003 Parameter TIMEOUT, default 1023, maximum clk cycles from conv_req to conv_done (1..65535).
REQ-004 clk  in  1  system clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  level; 1 = run periodic scans.
REQ-007 ch_mask  in  4  channel enable mask; bit n = channel n.
REQ-008 period  in  16  clk cycles between consecutive scan starts; 0 = back-to-back.
REQ-009 err_clr  in  1  single-cycle pulse; clears err_flags.
REQ-010 conv_req  out  1  single-cycle pulse; requests one conversion from the ADC serial reader.
REQ-011 conv_done  in  1  single-cycle pulse from the reader; conv_data valid in the same cycle.
REQ-012 conv_data  in  12  unsigned conversion result.
REQ-013 mux_sel  out  2  analog multiplexer channel select.
REQ-014 result_valid  out  1  single-cycle pulse; result_ch/result_data valid.
REQ-015 result_ch  out  2  channel of the current result.
REQ-016 result_data  out  12  averaged result.
REQ-017 scan_done  out  1  single-cycle pulse at the end of each scan.
REQ-018 busy  out  1  high in SETTLE, REQ, WAIT_DONE and NEXT states.
REQ-019 err_flags  out  4  sticky per-channel timeout flags.

Function
REQ-020 States: IDLE, WAIT_PERIOD, SETTLE, REQ, WAIT_DONE, NEXT.
REQ-021 IDLE -> SETTLE when enable=1 and ch_mask!=0. The period counter restarts at 0 on this transition; ch_mask is latched; mux_sel loads the lowest set bit.
REQ-022 Channels are visited in ascending order of the latched mask. Mask changes take effect only at the next scan start.
REQ-023 SETTLE lasts exactly SETTLE cycles, then moves to REQ. It is entered only before the first conversion of a channel.
REQ-024 REQ asserts conv_req for exactly one cycle, then moves to WAIT_DONE. The timeout counter clears on entry to WAIT_DONE.
REQ-025 In WAIT_DONE, conv_done adds conv_data to the (12+AVG_LOG2)-bit accumulator and increments the sample count.
  - Sample count < 2^AVG_LOG2: next state is REQ; no new settle.
  - Otherwise: next state is NEXT.
REQ-026 conv_done in any state other than WAIT_DONE, including the REQ cycle, is ignored.
REQ-027 In NEXT, for a channel whose conversions completed:
  - result_valid pulses for one cycle;
  - result_ch = channel;
  - result_data = accumulator >> AVG_LOG2 (truncating);
  - accumulator and sample count clear.
REQ-028 From NEXT:
  - Further latched mask bits remain: go to SETTLE with the next channel on mux_sel.
  - Otherwise: scan_done pulses in the same cycle as the last result_valid, then go to WAIT_PERIOD.
REQ-029 Timeout: if TIMEOUT cycles elapse in WAIT_DONE without conv_done:
  - set err_flags[channel];
  - discard the accumulator;
  - go to NEXT with no result_valid for that channel.
REQ-030 WAIT_PERIOD -> SETTLE when the period counter reaches period-1 and enable=1, counting from the previous scan start. If the scan ran longer than period, including period=0, go to SETTLE on the cycle after NEXT.
REQ-031 enable=0 in WAIT_PERIOD -> IDLE.
REQ-032 enable=0 while busy: the current WAIT_DONE completes (done or timeout), then go directly to IDLE.
  - No result_valid for the partial channel.
  - No scan_done.
REQ-033 ch_mask=0 at the scan start check -> remain in or return to IDLE.
REQ-034 err_clr clears all err_flags. If a timeout occurs in the same cycle, that channel's flag is set (set wins).
REQ-035 All outputs are registered; result_data and result_ch hold their value until the next result_valid.

Reset
REQ-036 rst asserted at any time, including mid-conversion: state = IDLE immediately. Cleared to 0: conv_req, result_valid, scan_done, busy, mux_sel, result_ch, result_data, err_flags, accumulator, all counters.
REQ-037 A conv_done arriving after reset release while in IDLE is ignored.

Verification
REQ-038 Stimulus: mask=0101, AVG_LOG2=2, period=2000, done 40 cycles after each req with data 100,101,102,103 (ch0) and 4095 x4 (ch2). Required response:
  - ch0: mux_sel=0, 16 settle cycles, 4 reqs, result_data=101;
  - ch2: mux_sel=2, result_data=4095 with scan_done in the same cycle;
  - next scan starts 2000 cycles after the first.
REQ-039 Stimulus: ch1 never answers, mask=0010, TIMEOUT=1023. Required response: err_flags=0010 exactly 1023 cycles after the first req; no result_valid; scan_done pulses. Then err_clr pulse -> err_flags=0000.
REQ-040 Stimulus: period=0, mask=1000. Required response: back-to-back scans; the second SETTLE begins the cycle after scan_done.
REQ-041 Stimulus: enable dropped during ch0 WAIT_DONE, mask=0011. Required response: after conv_done, IDLE; no result_valid; no scan_done; busy=0.
REQ-042 Stimulus: rst mid-WAIT_DONE, then a stray conv_done. Required response: all outputs 0; state IDLE; stray conv_done ignored.
REQ-043 Stimulus: conv_done during the REQ cycle. Required response: ignored; the accumulator is unchanged.
